// File: rtl/arith_encoder_controller.sv
// arith_encoder_controller: buffers symbol tuples and sequences init, issue, drain and flush of the AV1 arithmetic-encoder datapath
module arith_encoder_controller #(
  parameter int TB_RANGE_WIDTH  = 16,
  parameter int TB_SYMBOL_WIDTH = 4,
  parameter int TB_D_SIZE       = 4,
  parameter int PIPE_DEPTH      = 3
) (
  input  logic                       general_clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TB_RANGE_WIDTH-1:0]  in_fl,
  input  logic [TB_RANGE_WIDTH-1:0]  in_fh,
  input  logic [TB_SYMBOL_WIDTH-1:0] in_symbol,
  input  logic [TB_SYMBOL_WIDTH:0]   in_nsyms,
  input  logic                       in_last,
  output logic                       dp_init,
  output logic                       dp_valid,
  input  logic                       dp_stall,
  output logic [TB_RANGE_WIDTH-1:0]  dp_fl,
  output logic [TB_RANGE_WIDTH-1:0]  dp_fh,
  output logic [TB_SYMBOL_WIDTH-1:0] dp_symbol,
  output logic [TB_SYMBOL_WIDTH:0]   dp_nsyms,
  output logic                       dp_flush,
  input  logic                       dp_flush_done,
  output logic                       busy,
  output logic                       frame_done,
  output logic [31:0]                sym_count,
  output logic                       protocol_err
);
  localparam int AW = $clog2(TB_D_SIZE);
  localparam int DW = $clog2(PIPE_DEPTH + 1);
  localparam int EW = 2 * TB_RANGE_WIDTH + 2 * TB_SYMBOL_WIDTH + 2;
  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, FLUSH, DONE} state_t;
  state_t        state_q;
  logic [EW-1:0] mem_q [TB_D_SIZE];
  logic [AW:0]   wr_q, rd_q;
  logic [DW-1:0] drain_q;
  logic          last_q, flushed_q;
  logic [EW-2:0] hold_q;
  logic [EW-1:0] head;
  logic          full, empty, push, issue, bad;
  assign head       = mem_q[rd_q[AW-1:0]];
  assign empty      = wr_q == rd_q;
  assign full       = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign in_ready   = (state_q == INIT || state_q == RUN) && !full && !last_q;
  assign push       = in_valid && in_ready;
  assign issue      = state_q == RUN && !empty && !dp_stall;
  assign dp_valid   = issue;
  assign {dp_fl, dp_fh, dp_symbol, dp_nsyms} = issue ? head[EW-1:1] : hold_q;
  assign bad        = in_nsyms < (TB_SYMBOL_WIDTH + 1)'(2) || {1'b0, in_symbol} >= in_nsyms ||
                      (in_fl < in_fh && 32'(in_fl) < 32'd32768);
  assign dp_init    = state_q == INIT;
  assign dp_flush   = state_q == FLUSH && !flushed_q;
  assign busy       = state_q != IDLE;
  assign frame_done = state_q == DONE;
  always_ff @(posedge general_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_q         <= '0;
      rd_q         <= '0;
      drain_q      <= '0;
      last_q       <= 1'b0;
      flushed_q    <= 1'b0;
      hold_q       <= '0;
      sym_count    <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= {in_fl, in_fh, in_symbol, in_nsyms, in_last};
        wr_q                <= wr_q + 1'b1;
      end
      if (push && in_last) last_q <= 1'b1;
      if (push && bad) protocol_err <= 1'b1;
      if (issue) begin
        rd_q      <= rd_q + 1'b1;
        hold_q    <= head[EW-1:1];
        sym_count <= sym_count + 1;
      end
      case (state_q)
        IDLE: if (frame_start) begin
          state_q <= INIT;
          last_q  <= 1'b0;
        end
        INIT: begin
          state_q   <= RUN;
          sym_count <= '0;
        end
        RUN: if (issue && head[0]) begin
          state_q <= DRAIN;
          drain_q <= '0;
        end
        DRAIN: begin
          drain_q <= drain_q + 1'b1;
          if (drain_q == DW'(PIPE_DEPTH - 1)) begin
            state_q   <= FLUSH;
            flushed_q <= 1'b0;
          end
        end
        FLUSH: begin
          flushed_q <= 1'b1;
          if (dp_flush_done) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arith_encoder_controller.sv
// tb_arith_encoder_controller: randomized frames checked cycle by cycle against a queue-based reference model
module tb_arith_encoder_controller;
  localparam int D  = 4;
  localparam int PD = 3;
  typedef struct packed {
    logic [15:0] fl;
    logic [15:0] fh;
    logic [3:0]  sym;
    logic [4:0]  ns;
    logic        last;
  } tup_t;
  logic        general_clk = 1'b0;
  logic        reset = 1'b1, frame_start = 1'b0, in_valid = 1'b0, dp_stall = 1'b0, dp_flush_done = 1'b0;
  tup_t        cur = '0;
  logic        in_ready, dp_init, dp_valid, dp_flush, busy, frame_done, protocol_err;
  logic [15:0] dp_fl, dp_fh;
  logic [3:0]  dp_symbol;
  logic [4:0]  dp_nsyms;
  logic [31:0] sym_count;
  int          checks = 0, failures = 0;
  int          ph = 0;
  tup_t        mq[$];
  tup_t        m_hold = '0;
  tup_t        plan[$];
  logic [40:0] got_q[$];
  bit          m_last = 0, m_perr = 0, m_fsent = 0, m_push = 0, m_done = 0;
  int          m_dc = 0;
  logic [31:0] m_cnt = '0;
  always #5 general_clk = ~general_clk;
  arith_encoder_controller dut (
    .general_clk(general_clk), .reset(reset), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_fl(cur.fl), .in_fh(cur.fh),
    .in_symbol(cur.sym), .in_nsyms(cur.ns), .in_last(cur.last),
    .dp_init(dp_init), .dp_valid(dp_valid), .dp_stall(dp_stall),
    .dp_fl(dp_fl), .dp_fh(dp_fh), .dp_symbol(dp_symbol), .dp_nsyms(dp_nsyms),
    .dp_flush(dp_flush), .dp_flush_done(dp_flush_done), .busy(busy),
    .frame_done(frame_done), .sym_count(sym_count), .protocol_err(protocol_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic bit is_bad(input tup_t t);
    return t.ns < 5'd2 || {1'b0, t.sym} >= t.ns || (t.fl < t.fh && t.fl < 16'd32768);
  endfunction
  function automatic logic [40:0] key(input tup_t t);
    return {t.fl, t.fh, t.sym, t.ns};
  endfunction
  function automatic tup_t rand_tup();
    tup_t t;
    int   ns, fh;
    ns    = $urandom_range(2, 16);
    fh    = $urandom_range(0, 32767);
    t.ns  = 5'(ns);
    t.sym = 4'($urandom_range(0, ns - 1));
    t.fh  = 16'(fh);
    t.fl  = 16'($urandom_range(fh, 32768));
    t.last = 1'b0;
    return t;
  endfunction
  task automatic cyc();
    bit   e_ready, e_valid;
    tup_t e_dp, t;
    @(negedge general_clk);
    e_ready = (ph == 1 || ph == 2) && mq.size() < D && !m_last;
    e_valid = ph == 2 && mq.size() > 0 && !dp_stall;
    if (e_valid) e_dp = mq[0];
    else e_dp = m_hold;
    check("in_ready", in_ready, e_ready);
    check("dp_valid", dp_valid, e_valid);
    check("dp_init", dp_init, ph == 1);
    check("dp_flush", dp_flush, ph == 4 && !m_fsent);
    check("frame_done", frame_done, ph == 5);
    check("busy", busy, ph != 0);
    check("sym_count", sym_count, m_cnt);
    check("protocol_err", protocol_err, m_perr);
    check("dp_tuple", {dp_fl, dp_fh, dp_symbol, dp_nsyms}, key(e_dp));
    if (dp_valid) got_q.push_back({dp_fl, dp_fh, dp_symbol, dp_nsyms});
    @(posedge general_clk);
    m_push = 0;
    m_done = 0;
    if (reset) begin
      ph = 0; mq.delete(); m_last = 0; m_perr = 0; m_fsent = 0; m_cnt = '0; m_hold = '0; m_dc = 0;
    end else begin
      if (e_ready && in_valid) begin
        mq.push_back(cur);
        if (cur.last) m_last = 1;
        if (is_bad(cur)) m_perr = 1;
        m_push = 1;
      end
      t = '0;
      if (e_valid) begin
        t = mq.pop_front();
        m_hold = t;
        m_cnt++;
      end
      if (ph == 0) begin
        if (frame_start) begin ph = 1; m_last = 0; end
      end else if (ph == 1) begin
        ph = 2; m_cnt = '0;
      end else if (ph == 2) begin
        if (e_valid && t.last) begin ph = 3; m_dc = 0; end
      end else if (ph == 3) begin
        if (m_dc == PD - 1) begin ph = 4; m_fsent = 0; end
        else m_dc++;
      end else if (ph == 4) begin
        m_fsent = 1;
        if (dp_flush_done) ph = 5;
      end else begin
        ph = 0; m_done = 1;
      end
    end
    #1;
  endtask
  task automatic run_frame(input int smode, input bit b2b, input bit abort);
    int n, idx, fc, fwait, fdelay;
    bit fin;
    n = plan.size(); idx = 0; fc = 0; fwait = 0; fin = 0;
    fdelay = $urandom_range(0, 3);
    got_q.delete();
    frame_start = 1;
    cyc();
    frame_start = 0;
    for (int b = 0; b < 500 && !fin; b++) begin
      if (idx < n) begin
        cur = plan[idx];
        cur.last = idx == n - 1;
        in_valid = b2b || $urandom_range(0, 2) != 0;
      end else begin
        cur = rand_tup();
        cur.last = 1'($urandom);
        in_valid = 1'($urandom);
      end
      dp_stall = smode == 0 ? 1'b0 : smode == 1 ? $urandom_range(0, 2) == 0 :
                 smode == 2 ? fc[0] : fc < 8;
      frame_start = $urandom_range(0, 9) == 0;
      dp_flush_done = ph == 4 && fwait >= fdelay;
      if (ph == 4) fwait++;
      reset = abort && ph == 3;
      cyc();
      if (m_push) idx++;
      fc++;
      fin = m_done || (abort && reset);
    end
    reset = 0; in_valid = 0; dp_stall = 0; dp_flush_done = 0; frame_start = 0;
    check("frame_end", fin, 1);
    if (!abort) begin
      check("sym_count_end", sym_count, n);
      check("issued_n", got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++) check("issued_order", got_q[i], key(plan[i]));
    end
  endtask
  initial begin
    tup_t t;
    repeat (2) @(posedge general_clk);
    #1;
    reset = 0;
    in_valid = 1;
    cur = rand_tup();
    repeat (3) cyc();
    in_valid = 0;
    plan.delete();
    t = '0; t.fl = 16'd32768; t.fh = 16'd24576; t.sym = 4'd0; t.ns = 5'd3; plan.push_back(t);
    t.fl = 16'd24576; t.fh = 16'd8192; t.sym = 4'd1; plan.push_back(t);
    t.fl = 16'd8192; t.fh = 16'd0; t.sym = 4'd2; plan.push_back(t);
    run_frame(0, 1, 0);
    repeat (2) cyc();
    plan.delete();
    for (int i = 0; i < 6; i++) plan.push_back(rand_tup());
    run_frame(3, 1, 0);
    plan.delete();
    for (int i = 0; i < 10; i++) plan.push_back(rand_tup());
    run_frame(2, 1, 0);
    check("perr_clean", protocol_err, 0);
    plan.delete();
    plan.push_back(rand_tup());
    t = '0; t.fl = 16'd100; t.fh = 16'd200; t.sym = 4'd5; t.ns = 5'd3; plan.push_back(t);
    plan.push_back(rand_tup());
    run_frame(0, 1, 0);
    check("perr_set", protocol_err, 1);
    plan.delete();
    plan.push_back(rand_tup());
    run_frame(0, 1, 0);
    check("perr_sticky", protocol_err, 1);
    for (int f = 0; f < 8; f++) begin
      plan.delete();
      for (int i = 0, k = $urandom_range(1, 12); i < k; i++) plan.push_back(rand_tup());
      run_frame($urandom_range(0, 2), 1'($urandom), 0);
      repeat ($urandom_range(0, 2)) cyc();
    end
    plan.delete();
    for (int i = 0; i < 5; i++) plan.push_back(rand_tup());
    run_frame(0, 1, 1);
    repeat (4) cyc();
    check("perr_after_reset", protocol_err, 0);
    plan.delete();
    for (int i = 0; i < 4; i++) plan.push_back(rand_tup());
    run_frame(1, 0, 0);
    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arith_encoder_controller.md
Name: arith_encoder_controller

Overview:
- Sequences the AV1 arithmetic-encoder datapath for one frame at a time.
- Buffers incoming symbol tuples (fl, fh, symbol, nsyms) in a small FIFO and issues them to the encoder datapath, one per cycle, while honouring datapath stall.
- Initialises the datapath state (range=32768, low=0, cnt=-9) at frame start, drains the pipeline after the last symbol, then triggers and awaits the final flush.

Parameters:
- TB_RANGE_WIDTH, 16, width of fl/fh.
- TB_SYMBOL_WIDTH, 4, width of symbol; nsyms is TB_SYMBOL_WIDTH+1 bits.
- TB_D_SIZE, 4, input FIFO depth; power of two, >=2.
- PIPE_DEPTH, 3, datapath latency in cycles from dp_valid to state update; >=1.

Ports:
- general_clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid  in  1  symbol tuple present.
- in_ready  out  1  controller accepts the tuple this cycle.
- in_fl  in  TB_RANGE_WIDTH  CDF low bound.
- in_fh  in  TB_RANGE_WIDTH  CDF high bound.
- in_symbol  in  TB_SYMBOL_WIDTH  symbol index.
- in_nsyms  in  TB_SYMBOL_WIDTH+1  alphabet size.
- in_last  in  1  marks the final symbol of the frame.
- dp_init  out  1  one-cycle pulse: datapath loads range=32768, low=0, cnt=-9.
- dp_valid  out  1  issued tuple valid.
- dp_stall  in  1  datapath cannot take a tuple this cycle.
- dp_fl, dp_fh, dp_symbol, dp_nsyms  out  as inputs  issued tuple.
- dp_flush  out  1  one-cycle pulse to start the final flush.
- dp_flush_done  in  1  flush complete.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.
- sym_count  out  32  symbols issued in the current frame.
- protocol_err  out  1  sticky illegal-tuple flag.

Behaviour:
- Reset: state=IDLE, FIFO empty, all outputs 0, sym_count=0, protocol_err=0. Reset mid-frame aborts the frame without a flush; FIFO contents are discarded.
- States: IDLE, INIT, RUN, DRAIN, FLUSH, DONE.
- IDLE -> INIT on frame_start. frame_start in any other state is ignored.
- INIT lasts 1 cycle: dp_init=1, sym_count cleared, last_accepted cleared. Then -> RUN.
- FIFO push (INIT or RUN): in_ready = !fifo_full && !last_accepted; push when in_valid && in_ready. Accepting a tuple with in_last=1 sets last_accepted.
- in_ready does not look ahead at a same-cycle pop, so a full FIFO stalls input for one cycle even when popping.
- Issue (RUN only): when FIFO non-empty and dp_stall=0, pop the head and drive it on dp_* with dp_valid=1 the same cycle. Issue is combinational from the FIFO head, so a tuple pushed in cycle N issues no earlier than cycle N+1.
- Bubbles: FIFO empty or dp_stall=1 -> dp_valid=0, head held. dp_* hold their last value when dp_valid=0.
- Throughput: 1 tuple/cycle sustained.
- Each issue increments sym_count (wraps at 2^32).
- RUN -> DRAIN in the cycle the in_last tuple issues.
- DRAIN: count PIPE_DEPTH cycles, then -> FLUSH.
- FLUSH: dp_flush=1 on the first FLUSH cycle only. Wait for dp_flush_done=1, then -> DONE. A dp_flush_done seen in the same cycle as the dp_flush pulse is accepted.
- DONE lasts 1 cycle: frame_done=1. Then -> IDLE. sym_count holds until the next INIT.
- protocol_err is set at push when in_nsyms<2, in_symbol>=in_nsyms, or in_fl<in_fh while in_fl<32768. The tuple is still accepted and issued. Cleared only by reset.
- in_last with an empty frame (first tuple is last): issues normally, sym_count=1.
- in_valid during IDLE, DRAIN, FLUSH or DONE: in_ready=0, input not consumed.

Test Plan:
- Reset then idle -> all outputs 0, busy=0; in_valid=1 gives in_ready=0.
- frame_start, 3 tuples {fl=32768,fh=24576,sym=0,nsyms=3}, {24576,8192,1,3}, {8192,0,2,3 last} back-to-back, dp_stall=0 -> dp_init in cycle 1, then dp_valid for 3 consecutive cycles in order, DRAIN for 3 cycles, one dp_flush pulse; after dp_flush_done, frame_done pulses once and sym_count=3.
- 6 tuples pushed, dp_stall held 1 for 8 cycles -> in_ready falls after 4 accepts (FIFO full), no dp_valid during stall; on release all 6 issue in order, none lost or duplicated.
- dp_stall toggled every other cycle over 10 tuples -> dp_valid only on stall=0 cycles, sym_count=10, in_last tuple issued last.
- Tuple {fl=100,fh=200,sym=5,nsyms=3} -> protocol_err=1 and remains 1 across frames; tuple still issued.
- Reset asserted during DRAIN -> next cycle IDLE, no dp_flush; a new frame_start runs a full frame normally.
